// File: rtl/psram_arbiter.sv
// Two-port arbiter in front of a single PSRAM controller: one word access at a time,
// round-robin on ties, a forced gap cycle between accesses and a per-access watchdog.
module psram_arbiter #(
    parameter int unsigned AW      = 23,
    parameter int unsigned DW      = 16,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    // port A
    input  logic          i_a_req,
    input  logic          i_a_rw,
    input  logic [AW-1:0] i_a_addr,
    input  logic [DW-1:0] i_a_wdata,
    output logic          o_a_ack,
    output logic          o_a_done,
    output logic [DW-1:0] o_a_rdata,
    // port B
    input  logic          i_b_req,
    input  logic          i_b_rw,
    input  logic [AW-1:0] i_b_addr,
    input  logic [DW-1:0] i_b_wdata,
    output logic          o_b_ack,
    output logic          o_b_done,
    output logic [DW-1:0] o_b_rdata,
    // controller side
    input  logic          i_mem_initialized,
    input  logic          i_mem_ready,
    input  logic [DW-1:0] i_mem_data_out,
    output logic          o_mem,
    output logic          o_mem_rw,
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_data_in,
    output logic          o_busy,
    output logic          o_timeout_err
);

    localparam int unsigned WDW = $clog2(TIMEOUT + 1);
    // Last watchdog value spent in ACCESS: done lands TIMEOUT+1 cycles after ack.
    localparam logic [WDW-1:0] WDOG_LAST = WDW'(TIMEOUT);

    typedef enum logic [1:0] {StInit, StIdle, StAccess, StGap} state_e;

    state_e         r_state;
    state_e         w_state_d;
    logic           w_grant_a;
    logic           w_grant_b;
    logic           w_ready;
    logic           w_expire;

    logic           r_a_ack;
    logic           r_b_ack;
    logic           r_owner_b;
    logic           r_last_b;
    logic           r_mem_rw;
    logic [AW-1:0]  r_mem_addr;
    logic [DW-1:0]  r_mem_data_in;
    logic [DW-1:0]  r_a_rdata;
    logic [DW-1:0]  r_b_rdata;
    logic           r_timeout_err;
    logic [WDW-1:0] r_wdog;

    always_comb begin
        w_state_d = r_state;
        w_grant_a = 1'b0;
        w_grant_b = 1'b0;
        w_ready   = 1'b0;
        w_expire  = 1'b0;
        case (r_state)
            StInit: begin
                if (i_mem_initialized) w_state_d = StIdle;
            end
            StIdle: begin
                // On a tie, the port that did not own the previous access wins.
                if (i_a_req && (!i_b_req || r_last_b)) begin
                    w_grant_a = 1'b1;
                end else if (i_b_req) begin
                    w_grant_b = 1'b1;
                end
                if (w_grant_a || w_grant_b) w_state_d = StAccess;
            end
            StAccess: begin
                if (i_mem_ready) begin
                    w_ready   = 1'b1;
                    w_state_d = StGap;
                end else if (r_wdog == WDOG_LAST) begin
                    w_expire  = 1'b1;
                    w_state_d = StGap;
                end
            end
            StGap: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StInit;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= StInit;
            r_a_ack       <= 1'b0;
            r_b_ack       <= 1'b0;
            r_owner_b     <= 1'b0;
            r_last_b      <= 1'b1;
            r_mem_rw      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_data_in <= '0;
            r_a_rdata     <= '0;
            r_b_rdata     <= '0;
            r_timeout_err <= 1'b0;
            r_wdog        <= '0;
        end else begin
            r_state <= w_state_d;
            r_a_ack <= w_grant_a;
            r_b_ack <= w_grant_b;
            if (w_grant_a || w_grant_b) begin
                r_mem_rw      <= w_grant_a ? i_a_rw    : i_b_rw;
                r_mem_addr    <= w_grant_a ? i_a_addr  : i_b_addr;
                r_mem_data_in <= w_grant_a ? i_a_wdata : i_b_wdata;
                r_owner_b     <= w_grant_b;
                r_last_b      <= w_grant_b;
                r_wdog        <= '0;
            end else if (r_state == StAccess) begin
                r_wdog <= r_wdog + WDW'(1);
            end
            if (w_ready && r_mem_rw) begin
                if (r_owner_b) r_b_rdata <= i_mem_data_out;
                else           r_a_rdata <= i_mem_data_out;
            end
            if (w_expire) r_timeout_err <= 1'b1;
        end
    end

    assign o_mem         = (r_state == StAccess);
    assign o_busy        = (r_state != StIdle);
    assign o_a_ack       = r_a_ack;
    assign o_b_ack       = r_b_ack;
    assign o_a_done      = (r_state == StGap) && !r_owner_b;
    assign o_b_done      = (r_state == StGap) && r_owner_b;
    assign o_a_rdata     = r_a_rdata;
    assign o_b_rdata     = r_b_rdata;
    assign o_mem_rw      = r_mem_rw;
    assign o_mem_addr    = r_mem_addr;
    assign o_mem_data_in = r_mem_data_in;
    assign o_timeout_err = r_timeout_err;

endmodule
